// File: rtl/instr_bram_loader.sv
// Packs the decoded instruction byte stream into 32-bit BRAM writes with byte enables and holds the core in reset while loading.
// Latency: a write appears one cycle after its triggering byte. No backpressure: a byte is accepted every cycle it is strobed.
module instr_bram_loader #(
    parameter int MEM_ADDR_W  = 12,
    parameter int RELEASE_DLY = 16
) (
    input  logic                  clk_user,
    input  logic                  reset,
    input  logic                  instr_wr_en,
    input  logic [23:0]           addr,
    input  logic [7:0]            din,
    output logic [3:0]            mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  load_busy,
    output logic [15:0]           words_written,
    output logic                  addr_err
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    localparam int         CNT_W    = $clog2(RELEASE_DLY + 1);
    localparam logic [7:0] OP_START = 8'h01;
    localparam logic [7:0] OP_DONE  = 8'h02;
    // Byte-address bits between the BRAM range and the control flag.
    localparam logic [23:0] OOB_MASK =
        ((24'h1 << 23) - 24'h1) & ~((24'h1 << (MEM_ADDR_W + 2)) - 24'h1);

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [MEM_ADDR_W-1:0]  buf_addr, buf_addr_nxt;
    logic [31:0]            buf_data, buf_data_nxt;
    logic [3:0]             buf_mask, buf_mask_nxt;
    logic                   err_nxt;
    logic                   clr_cnt;

    logic                   wr_go;
    logic [MEM_ADDR_W-1:0]  wr_addr;
    logic [31:0]            wr_data;
    logic [3:0]             wr_mask;

    logic                   is_ctrl, is_data, oob, data_ok, is_start, is_done;
    logic [MEM_ADDR_W-1:0]  in_word;
    logic [1:0]             in_lane;
    logic [3:0]             lane_mask;
    logic [31:0]            lane_bits, lane_data;
    logic [31:0]            merged_data;
    logic [3:0]             merged_mask;

    assign is_ctrl  = instr_wr_en & addr[23];
    assign is_data  = instr_wr_en & ~addr[23];
    assign oob      = |(addr & OOB_MASK);
    assign data_ok  = is_data & ~oob;
    assign is_start = is_ctrl && (din == OP_START);
    assign is_done  = is_ctrl && (din == OP_DONE);

    assign in_word   = addr[MEM_ADDR_W+1:2];
    assign in_lane   = addr[1:0];
    assign lane_mask = 4'b0001 << in_lane;
    assign lane_bits = 32'h0000_00FF << {in_lane, 3'b000};
    assign lane_data = {24'h00_0000, din} << {in_lane, 3'b000};

    assign merged_data = (buf_data & ~lane_bits) | lane_data;
    assign merged_mask = buf_mask | lane_mask;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        buf_addr_nxt = buf_addr;
        buf_data_nxt = buf_data;
        buf_mask_nxt = buf_mask;
        err_nxt      = addr_err;
        clr_cnt      = 1'b0;
        wr_go        = 1'b0;
        wr_addr      = buf_addr;
        wr_data      = buf_data;
        wr_mask      = buf_mask;

        if (is_start) begin
            buf_data_nxt = '0;
            buf_mask_nxt = '0;
            err_nxt      = 1'b0;
            clr_cnt      = 1'b1;
            cnt_nxt      = '0;
            state_nxt    = ST_LOAD;
        end else begin
            if (is_done) begin
                if (buf_mask != 4'h0) begin
                    wr_go        = 1'b1;
                    buf_data_nxt = '0;
                    buf_mask_nxt = '0;
                end
            end else if (is_data && oob) begin
                err_nxt = 1'b1;
            end else if (data_ok) begin
                if (buf_mask == 4'h0) begin
                    buf_addr_nxt = in_word;
                    buf_data_nxt = lane_data;
                    buf_mask_nxt = lane_mask;
                end else if (buf_addr == in_word) begin
                    if (merged_mask == 4'hF) begin
                        wr_go        = 1'b1;
                        wr_data      = merged_data;
                        wr_mask      = 4'hF;
                        buf_data_nxt = '0;
                        buf_mask_nxt = '0;
                    end else begin
                        buf_data_nxt = merged_data;
                        buf_mask_nxt = merged_mask;
                    end
                end else begin
                    // Retire the old word and open the new one on the same edge.
                    wr_go        = 1'b1;
                    buf_addr_nxt = in_word;
                    buf_data_nxt = lane_data;
                    buf_mask_nxt = lane_mask;
                end
            end

            case (state)
                ST_LOAD: begin
                    if (is_done) begin
                        cnt_nxt   = CNT_W'(RELEASE_DLY);
                        state_nxt = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_nxt = ST_RUN;
                end
                default: begin
                    state_nxt = ST_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk_user or posedge reset) begin
        if (reset) begin
            state         <= ST_LOAD;
            cnt           <= '0;
            buf_addr      <= '0;
            buf_data      <= '0;
            buf_mask      <= '0;
            mem_we        <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            words_written <= '0;
            addr_err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            buf_addr <= buf_addr_nxt;
            buf_data <= buf_data_nxt;
            buf_mask <= buf_mask_nxt;
            addr_err <= err_nxt;
            mem_we   <= wr_go ? wr_mask : 4'h0;
            if (wr_go) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end
            if (clr_cnt) begin
                words_written <= '0;
            end else if (wr_go && (words_written != 16'hFFFF)) begin
                words_written <= words_written + 16'h0001;
            end
        end
    end

    assign cpu_reset = (state != ST_RUN);
    assign load_busy = (state != ST_RUN);

endmodule

// File: tb/tb_instr_bram_loader.sv
// Directed and random byte streams checked against a per-transaction reference model of the loader.
module tb_instr_bram_loader;

    localparam int MW  = 12;
    localparam int DLY = 16;

    logic          clk_user;
    logic          reset;
    logic          instr_wr_en;
    logic [23:0]   addr;
    logic [7:0]    din;
    logic [3:0]    mem_we;
    logic [MW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          load_busy;
    logic [15:0]   words_written;
    logic          addr_err;

    instr_bram_loader #(.MEM_ADDR_W(MW), .RELEASE_DLY(DLY)) dut (
        .clk_user      (clk_user),
        .reset         (reset),
        .instr_wr_en   (instr_wr_en),
        .addr          (addr),
        .din           (din),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .cpu_reset     (cpu_reset),
        .load_busy     (load_busy),
        .words_written (words_written),
        .addr_err      (addr_err)
    );

    initial begin
        clk_user = 1'b0;
        forever #5 clk_user = ~clk_user;
    end

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: pending word as four optional bytes, plus release countdown.
    int         m_word;
    logic [7:0] m_bytes [4];
    bit         m_have  [4];
    int         m_count;
    bit         m_err;
    bit         m_running;
    int         m_rel_left;
    logic [3:0]  e_we;
    logic [31:0] e_addr;
    logic [31:0] e_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_word = -1;
        for (int k = 0; k < 4; k++) begin
            m_have[k]  = 1'b0;
            m_bytes[k] = 8'h00;
        end
        m_count    = 0;
        m_err      = 1'b0;
        m_running  = 1'b0;
        m_rel_left = 0;
    endtask

    task automatic emit();
        e_we   = 4'h0;
        e_data = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (m_have[k]) begin
                e_we[k]         = 1'b1;
                e_data[8*k +: 8] = m_bytes[k];
            end
            m_have[k] = 1'b0;
        end
        e_addr = m_word;
        m_word = -1;
        if (m_count < 65535) m_count++;
    endtask

    task automatic step(input bit we, input logic [23:0] a, input logic [7:0] d);
        bit loading;
        int w;
        int l;
        instr_wr_en = we;
        addr        = a;
        din         = d;
        @(posedge clk_user);
        #1;
        instr_wr_en = 1'b0;
        e_we    = 4'h0;
        loading = !m_running && (m_rel_left == 0);
        if (we && a[23] && d == 8'h01) begin
            m_word = -1;
            for (int k = 0; k < 4; k++) m_have[k] = 1'b0;
            m_count    = 0;
            m_err      = 1'b0;
            m_running  = 1'b0;
            m_rel_left = 0;
        end else begin
            if (m_rel_left > 0) begin
                m_rel_left--;
                if (m_rel_left == 0) m_running = 1'b1;
            end
            if (we && a[23] && d == 8'h02) begin
                if (m_word >= 0) emit();
                if (loading) m_rel_left = DLY;
            end else if (we && !a[23]) begin
                if (a[22:MW+2] != '0) begin
                    m_err = 1'b1;
                end else begin
                    w = int'(a[MW+1:2]);
                    l = int'(a[1:0]);
                    if (m_word >= 0 && m_word != w) emit();
                    m_word     = w;
                    m_bytes[l] = d;
                    m_have[l]  = 1'b1;
                    if (m_have[0] && m_have[1] && m_have[2] && m_have[3]) emit();
                end
            end
        end
        chk("we", mem_we, e_we);
        if (e_we != 4'h0) begin
            chk("addr", mem_addr, e_addr);
            chk("wdata", mem_wdata, e_data);
        end
        chk("words", words_written, m_count);
        chk("addr_err", addr_err, m_err);
        chk("cpu_reset", cpu_reset, !m_running);
        chk("load_busy", load_busy, !m_running);
    endtask

    task automatic idle();
        step(1'b0, 24'h0, 8'h0);
    endtask

    localparam logic [23:0] CTRL = 24'h80_0000;

    initial begin
        logic [23:0] ra;
        int          sel;

        reset       = 1'b1;
        instr_wr_en = 1'b0;
        addr        = '0;
        din         = '0;
        model_reset();
        #1;
        chk("rst_we", mem_we, 4'h0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_busy", load_busy, 1);
        chk("rst_words", words_written, 0);
        chk("rst_err", addr_err, 0);
        repeat (2) @(posedge clk_user);
        #1;
        reset = 1'b0;

        // Full word assembled from four back-to-back bytes
        step(1'b1, CTRL, 8'h01);
        step(1'b1, 24'h000100, 8'hEF);
        step(1'b1, 24'h000101, 8'hBE);
        step(1'b1, 24'h000102, 8'hAD);
        step(1'b1, 24'h000103, 8'hDE);
        chk("full_we", mem_we, 4'hF);
        chk("full_addr", mem_addr, 12'h040);
        chk("full_data", mem_wdata, 32'hDEADBEEF);
        chk("full_words", words_written, 1);
        idle();
        chk("full_we_one_cycle", mem_we, 4'h0);

        // Partial words retired by a word change and by DONE
        step(1'b1, 24'h000008, 8'h11);
        step(1'b1, 24'h00000A, 8'h22);
        step(1'b1, 24'h000010, 8'h33);
        chk("part_we", mem_we, 4'b0101);
        chk("part_addr", mem_addr, 2);
        chk("part_data", mem_wdata, 32'h0022_0011);
        step(1'b1, CTRL, 8'h02);
        chk("flush_we", mem_we, 4'b0001);
        chk("flush_addr", mem_addr, 4);
        chk("flush_data", mem_wdata, 32'h0000_0033);
        chk("flush_cpu_reset", cpu_reset, 1);
        repeat (DLY - 1) idle();
        chk("rel_hold_cpu_reset", cpu_reset, 1);
        chk("rel_hold_busy", load_busy, 1);
        idle();
        chk("rel_cpu_reset", cpu_reset, 0);
        chk("rel_busy", load_busy, 0);

        // Out-of-range byte dropped, START clears the sticky error
        step(1'b1, 24'h004000, 8'h55);
        chk("oob_we", mem_we, 4'h0);
        chk("oob_err", addr_err, 1);
        step(1'b1, CTRL, 8'h01);
        chk("start_err", addr_err, 0);
        chk("start_cpu_reset", cpu_reset, 1);
        chk("start_words", words_written, 0);

        // START discards a pending partial word
        step(1'b1, 24'h000020, 8'hA1);
        step(1'b1, 24'h000021, 8'hA2);
        step(1'b1, CTRL, 8'h01);
        chk("discard_we", mem_we, 4'h0);
        chk("discard_words", words_written, 0);
        chk("discard_cpu_reset", cpu_reset, 1);

        // Asynchronous reset in RELEASE while a flush write is on the port
        step(1'b1, 24'h000030, 8'h77);
        step(1'b1, CTRL, 8'h02);
        chk("pre_arst_we", mem_we, 4'b0001);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst_we", mem_we, 4'h0);
        chk("arst_cpu_reset", cpu_reset, 1);
        chk("arst_busy", load_busy, 1);
        chk("arst_words", words_written, 0);
        chk("arst_addr", mem_addr, 0);
        #2;
        reset = 1'b0;
        idle();
        idle();
        step(1'b1, CTRL, 8'h02);
        repeat (DLY - 1) idle();
        chk("arst_rel_hold", cpu_reset, 1);
        idle();
        chk("arst_rel_done", cpu_reset, 0);

        // Random mix of data bytes, control opcodes and idle cycles
        for (int i = 0; i < 800; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 60) begin
                ra = {10'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
                step(1'b1, ra, 8'($urandom));
            end else if (sel < 64) begin
                ra = (24'h1 << $urandom_range(MW + 2, 22)) | 24'($urandom_range(0, 255));
                step(1'b1, ra, 8'($urandom));
            end else if (sel < 67) begin
                step(1'b1, CTRL, 8'h01);
            end else if (sel < 71) begin
                step(1'b1, CTRL, 8'h02);
            end else if (sel < 74) begin
                step(1'b1, CTRL | 24'($urandom_range(0, 1023)), 8'($urandom_range(3, 255)));
            end else begin
                idle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
